// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - 128x32 data-memory responder with posted store buffer, load forwarding and host port
// Optional DMEM_STATS_EN adds saturating CPU load/store counters (stat_loads, stat_stores).
module dmem_responder #(
    parameter int SB_DEPTH = 4,
    parameter int AW       = 7,
    parameter int DW       = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          CEN,
    input  logic          WEN,
    input  logic          OEN,
    input  logic [AW-1:0] A,
    input  logic [DW-1:0] D,
    output logic [DW-1:0] Q,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ready,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic [3:0]    sb_count,
    output logic          sb_overflow
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0]   stat_loads,
    output logic [15:0]   stat_stores
`endif
);

    localparam int PW = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;

    logic [DW-1:0] mem     [2**AW];
    logic [AW-1:0] sb_addr [SB_DEPTH];
    logic [DW-1:0] sb_data [SB_DEPTH];
    logic [PW-1:0] head, tail;
    logic [3:0]    count;

    logic cpu_wr, cpu_rd, sb_full, sb_empty, push, drop, pop, host_xfer;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(SB_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign cpu_wr     = ~CEN & ~WEN;
    assign cpu_rd     = ~CEN & WEN & ~OEN;
    assign sb_full    = (count == 4'(SB_DEPTH));
    assign sb_empty   = (count == 4'd0);
    assign push       = cpu_wr & ~sb_full;
    assign drop       = cpu_wr & sb_full;
    // The array port drains only when the CPU leaves it idle, so push and pop never coincide.
    assign pop        = CEN & ~sb_empty;
    assign host_ready = host_req & CEN & sb_empty;
    assign host_xfer  = host_ready;
    assign sb_count   = count;

    // Walk oldest to youngest so the last hit is the newest store to A.
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic [PW-1:0] idx;
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = head;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if ((4'(i) < count) && (sb_addr[idx] == A)) begin
                fwd_hit  = 1'b1;
                fwd_data = sb_data[idx];
            end
            idx = next_ptr(idx);
        end
    end

    assign Q = cpu_rd ? (fwd_hit ? fwd_data : mem[A]) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head        <= '0;
            tail        <= '0;
            count       <= 4'd0;
            sb_overflow <= 1'b0;
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
        end else begin
            if (push) begin
                tail  <= next_ptr(tail);
                count <= count + 4'd1;
            end else if (pop) begin
                head  <= next_ptr(head);
                count <= count - 4'd1;
            end
            if (drop) begin
                sb_overflow <= 1'b1;
            end
            host_rvalid <= host_xfer & ~host_we;
            if (host_xfer & ~host_we) begin
                host_rdata <= mem[host_addr];
            end
        end
    end

    // Storage arrays carry no reset; occupancy is tracked by count/pointers above.
    always_ff @(posedge clk) begin
        if (push) begin
            sb_addr[tail] <= A;
            sb_data[tail] <= D;
        end
        if (pop) begin
            mem[sb_addr[head]] <= sb_data[head];
        end else if (host_xfer & host_we) begin
            mem[host_addr] <= host_wdata;
        end
    end

`ifdef DMEM_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_loads  <= 16'd0;
            stat_stores <= 16'd0;
        end else begin
            if (cpu_rd && stat_loads != 16'hFFFF) begin
                stat_loads <= stat_loads + 16'd1;
            end
            if (push && stat_stores != 16'hFFFF) begin
                stat_stores <= stat_stores + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed and randomized checks of dmem_responder against a queue-based model
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        CEN = 1'b1, WEN = 1'b1, OEN = 1'b1;
    logic [6:0]  A = '0, host_addr = '0;
    logic [31:0] D = '0, host_wdata = '0;
    logic        host_req = 1'b0, host_we = 1'b0;
    logic [31:0] Q, host_rdata;
    logic        host_ready, host_rvalid, sb_overflow;
    logic [3:0]  sb_count;

    dmem_responder #(.SB_DEPTH(4), .AW(7), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n), .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A), .D(D), .Q(Q),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ready(host_ready), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .sb_count(sb_count), .sb_overflow(sb_overflow)
    );

    always #5 clk = ~clk;

    logic [31:0] mem_m [128];
    logic [38:0] sbq [$];
    logic        ovf_m = 1'b0;
    logic        rvalid_m = 1'b0;
    logic [31:0] rdata_m = '0;
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_q();
        if (!CEN && WEN && !OEN) begin
            for (int i = sbq.size() - 1; i >= 0; i--)
                if (sbq[i][38:32] == A) return sbq[i][31:0];
            return mem_m[A];
        end
        return 32'd0;
    endfunction

    // One clock: check outputs at the falling edge, advance the model, then the rising edge.
    task automatic step();
        logic [38:0] e;
        logic        rv_next;
        @(negedge clk);
        chk("Q", Q, exp_q());
        chk("host_ready", 32'(host_ready), 32'(host_req && CEN && sbq.size() == 0));
        chk("sb_count", 32'(sb_count), 32'(sbq.size()));
        chk("sb_overflow", 32'(sb_overflow), 32'(ovf_m));
        chk("host_rvalid", 32'(host_rvalid), 32'(rvalid_m));
        if (rvalid_m) chk("host_rdata", host_rdata, rdata_m);
        rv_next = 1'b0;
        if (!CEN) begin
            if (!WEN) begin
                if (sbq.size() < 4) sbq.push_back({A, D});
                else ovf_m = 1'b1;
            end
        end else if (sbq.size() > 0) begin
            e = sbq.pop_front();
            mem_m[e[38:32]] = e[31:0];
        end else if (host_req) begin
            if (host_we) mem_m[host_addr] = host_wdata;
            else begin
                rdata_m = mem_m[host_addr];
                rv_next = 1'b1;
            end
        end
        rvalid_m = rv_next;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3;
        chk("reset sb_count", 32'(sb_count), 32'd0);
        chk("reset sb_overflow", 32'(sb_overflow), 32'd0);
        chk("reset host_rvalid", 32'(host_rvalid), 32'd0);
        chk("reset host_rdata", host_rdata, 32'd0);
        chk("reset host_ready", 32'(host_ready), 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Preload every word so the model knows the whole array.
        host_req = 1'b1; host_we = 1'b1;
        for (int a = 0; a < 128; a++) begin
            host_addr = 7'(a); host_wdata = $urandom;
            step();
        end

        // Host write then read of address 5.
        host_addr = 7'd5; host_wdata = 32'h0000_00AA;
        step();
        host_we = 1'b0;
        step();
        host_req = 1'b0;
        chk("host rvalid after read", 32'(host_rvalid), 32'd1);
        chk("host rdata addr5", host_rdata, 32'h0000_00AA);
        step();
        chk("host rvalid one pulse", 32'(host_rvalid), 32'd0);

        // Store then forwarded load at A=3; drain on first idle cycle.
        CEN = 1'b0; WEN = 1'b0; A = 7'd3; D = 32'h1234_5678;
        step();
        WEN = 1'b1; OEN = 1'b0; #1;
        chk("forward A3", Q, 32'h1234_5678);
        chk("sb_count one store", 32'(sb_count), 32'd1);
        step();
        CEN = 1'b1; OEN = 1'b1;
        step();
        chk("sb_count drained", 32'(sb_count), 32'd0);
        CEN = 1'b0; OEN = 1'b0; #1;
        chk("array A3 after drain", Q, 32'h1234_5678);
        step();

        // Two stores to A=9, youngest wins; host sees it after drain.
        WEN = 1'b0; A = 7'd9; D = 32'h11;
        step();
        D = 32'h22;
        step();
        WEN = 1'b1; #1;
        chk("youngest forward A9", Q, 32'h22);
        step();
        CEN = 1'b1; OEN = 1'b1;
        step(); step();
        host_req = 1'b1; host_we = 1'b0; host_addr = 7'd9;
        step();
        host_req = 1'b0;
        chk("host read A9", host_rdata, 32'h22);
        step();

        // Five stores into a four-deep buffer.
        CEN = 1'b0; WEN = 1'b0;
        for (int i = 0; i < 5; i++) begin
            A = 7'(20 + i); D = $urandom;
            step();
        end
        chk("sb_count full", 32'(sb_count), 32'd4);
        chk("overflow set", 32'(sb_overflow), 32'd1);
        CEN = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("sb_count after full drain", 32'(sb_count), 32'd0);
        chk("overflow sticky", 32'(sb_overflow), 32'd1);

        // Host blocked by CPU stores and the drain that follows.
        host_req = 1'b1; host_we = 1'b1; host_addr = 7'd40; host_wdata = 32'hCAFE_0040;
        CEN = 1'b0; WEN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            A = 7'(i); D = $urandom; #1;
            chk("host blocked by store", 32'(host_ready), 32'd0);
            step();
        end
        CEN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("host blocked by drain", 32'(host_ready), 32'd0);
            step();
        end
        #1 chk("host ready after drain", 32'(host_ready), 32'd1);
        step();
        host_req = 1'b0;
        CEN = 1'b0; WEN = 1'b1; OEN = 1'b0; A = 7'd40; #1;
        chk("host write landed", Q, 32'hCAFE_0040);
        step();

        // Asynchronous reset in the middle of a drain.
        WEN = 1'b0; OEN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            A = 7'(50 + i); D = $urandom;
            step();
        end
        CEN = 1'b1;
        step();
        chk("sb_count mid drain", 32'(sb_count), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset sb_count", 32'(sb_count), 32'd0);
        chk("async reset overflow", 32'(sb_overflow), 32'd0);
        chk("async reset rvalid", 32'(host_rvalid), 32'd0);
        sbq.delete(); ovf_m = 1'b0; rvalid_m = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomized traffic on a narrow address range to exercise forwarding.
        for (int n = 0; n < 400; n++) begin
            CEN = 1'($urandom_range(0, 1));
            WEN = 1'($urandom_range(0, 1));
            OEN = ($urandom_range(0, 3) == 0);
            A = 7'($urandom_range(0, 15));
            D = $urandom;
            host_req = 1'($urandom_range(0, 1));
            host_we = 1'($urandom_range(0, 1));
            host_addr = 7'($urandom_range(0, 15));
            host_wdata = $urandom;
            step();
        end
        CEN = 1'b1; host_req = 1'b0;
        for (int i = 0; i < 6; i++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
